// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmitter between a ROM message player and an RX echo
//   path. Each source owns a one-byte holding register with a pending flag; a
//   per-byte arbiter (round-robin on ties) moves one of them into a registered
//   valid/ready output stage that feeds the UART TX state machine.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   msg_start_i           start a message (ignored while msg_busy_o=1)
//   msg_base_i            first ROM address, sampled with msg_start_i
//   msg_busy_o            message playback in progress
//   msg_done_o            one-cycle pulse at message end
//   rom_addr_o            registered ROM read address
//   rom_data_i            ROM data, valid one cycle after rom_addr_o
//   rx_valid_i/rx_data_i  received byte strobe and byte
//   echo_en_i             enables echo of received bytes
//   echo_ovf_o            one-cycle pulse when an echo byte is dropped
//   tx_valid_o/tx_data_o  byte offered to the UART TX
//   tx_ready_i            UART TX idle; transfer on tx_valid_o & tx_ready_i
module uart_tx_scheduler #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int ROM_DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg_start_i,
  input  logic [ADDR_W-1:0] msg_base_i,
  output logic              msg_busy_o,
  output logic              msg_done_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              echo_en_i,
  output logic              echo_ovf_o,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i
);

  typedef enum logic [2:0] {M_IDLE, M_READ, M_LATCH, M_WAIT, M_DONE} mstate_t;

  // One extra bit so a depth of 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

  mstate_t           state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic              msg_set;
  logic [DATA_W-1:0] msg_buf, echo_buf;
  logic              msg_pend, echo_pend;
  logic              last_echo;
  logic              arb_idle, grant_msg, grant_echo;
  logic              rx_take, echo_accept, echo_drop;

  // ---- arbiter: only when the output stage is empty ----
  assign arb_idle   = ~tx_valid_o;
  assign grant_msg  = arb_idle & msg_pend  & (~echo_pend | last_echo);
  assign grant_echo = arb_idle & echo_pend & (~msg_pend  | ~last_echo);

  // An echo byte may overwrite echo_buf in the same cycle the old one is
  // granted, since the output stage captures the old value on that edge.
  assign rx_take     = rx_valid_i & echo_en_i;
  assign echo_accept = rx_take & (~echo_pend | grant_echo);
  assign echo_drop   = rx_take & echo_pend & ~grant_echo;

  assign msg_busy_o = (state != M_IDLE);
  assign rom_addr_o = ptr;

  // ---- message sequencer: next state ----
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    msg_set = 1'b0;
    case (state)
      M_IDLE: begin
        if (msg_start_i) begin
          ptr_d   = msg_base_i;
          state_d = ({1'b0, msg_base_i} >= DEPTH_EXT) ? M_DONE : M_READ;
        end
      end
      M_READ:  state_d = M_LATCH;
      M_LATCH: begin
        if (rom_data_i == '0) begin
          state_d = M_DONE;
        end else begin
          msg_set = 1'b1;
          state_d = M_WAIT;
        end
      end
      M_WAIT: begin
        if (grant_msg) begin
          if (ptr == LAST_ADDR) begin
            state_d = M_DONE;
          end else begin
            ptr_d   = ptr + 1'b1;
            state_d = M_READ;
          end
        end
      end
      M_DONE:  state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= M_IDLE;
      ptr        <= '0;
      msg_done_o <= 1'b0;
      msg_pend   <= 1'b0;
      echo_pend  <= 1'b0;
      echo_ovf_o <= 1'b0;
      last_echo  <= 1'b1;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      msg_done_o <= (state == M_DONE);
      echo_ovf_o <= echo_drop;

      if (msg_set)        msg_pend <= 1'b1;
      else if (grant_msg) msg_pend <= 1'b0;

      if (echo_accept)     echo_pend <= 1'b1;
      else if (grant_echo) echo_pend <= 1'b0;

      // ---- output stage ----
      if (tx_valid_o) begin
        if (tx_ready_i) tx_valid_o <= 1'b0;
      end else if (grant_msg) begin
        tx_valid_o <= 1'b1;
        tx_data_o  <= msg_buf;
        last_echo  <= 1'b0;
      end else if (grant_echo) begin
        tx_valid_o <= 1'b1;
        tx_data_o  <= echo_buf;
        last_echo  <= 1'b1;
      end
    end
  end

  // ---- holding registers (qualified by the pend flags) ----
  always_ff @(posedge clk) begin
    if (msg_set)     msg_buf  <= rom_data_i;
    if (echo_accept) echo_buf <= rx_data_i;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single UART transmitter between two byte sources: a ROM message player and an RX echo path. Sits between the UART receiver/ROM on one side and the UART TX state machine on the other, presenting one byte at a time on a valid/ready handshake. Arbitrates per byte with round-robin on ties, and sequences ROM reads for zero-terminated messages.

## Interface
- DATA_W, 8, byte width
- ADDR_W, 8, ROM address width
- ROM_DEPTH, 128, ROM entries; must be ≤ 2**ADDR_W
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- msg_start_i  in  1  start pulse; ignored while msg_busy_o=1
- msg_base_i  in  ADDR_W  first ROM address, sampled with msg_start_i
- msg_busy_o  out  1  message playback in progress
- msg_done_o  out  1  one-cycle pulse at message end
- rom_addr_o  out  ADDR_W  ROM read address (registered)
- rom_data_i  in  DATA_W  ROM data, valid one cycle after rom_addr_o
- rx_valid_i  in  1  received byte strobe (one cycle)
- rx_data_i  in  DATA_W  received byte
- echo_en_i  in  1  enables echo of received bytes
- echo_ovf_o  out  1  one-cycle pulse: echo byte dropped
- tx_valid_o  out  1  byte offered to UART TX
- tx_data_o  out  DATA_W  byte to transmit
- tx_ready_i  in  1  UART TX idle; transfer when tx_valid_o & tx_ready_i

## Operation
- Sources each own one holding register + pend flag: msg_buf/msg_pend, echo_buf/echo_pend.
- Output stage: tx_valid_o/tx_data_o registered; held stable until transfer; cleared on the transfer edge. Loaded only when tx_valid_o=0 (one bubble cycle minimum between bytes).
- Arbiter, evaluated when tx_valid_o=0: one pend set → grant it; both set → grant source not granted last; granted pend cleared and last_grant updated on the same edge.
- Echo: rx_valid_i & echo_en_i loads echo_buf and sets echo_pend if echo_pend=0 or echo is granted that cycle (pend stays 1 with new byte). Otherwise byte dropped, echo_ovf_o pulses. rx_valid_i with echo_en_i=0: ignored, no ovf.
- Message FSM:
  - M_IDLE: msg_start_i → ptr<=msg_base_i, M_READ; if msg_base_i ≥ ROM_DEPTH → M_DONE, no bytes.
  - M_READ: rom_addr_o=ptr presented → M_LATCH.
  - M_LATCH: rom_data_i=0x00 → M_DONE (terminator not sent); else msg_buf<=data, msg_pend<=1 → M_WAIT.
  - M_WAIT: on message grant: ptr=ROM_DEPTH-1 → M_DONE (no wrap); else ptr+1, → M_READ.
  - M_DONE: msg_done_o=1 for one cycle → M_IDLE.
- msg_busy_o=1 in every state except M_IDLE. rom_addr_o tracks ptr (ADDR_W, unsigned).

## Timing
- Reset values: tx_valid_o 0, tx_data_o 0, rom_addr_o 0, msg_busy_o 0, msg_done_o 0, echo_ovf_o 0; both pends 0; last_grant=echo (message wins first tie); FSM M_IDLE.
- Reset asserted mid-operation: all pending/in-flight bytes discarded immediately; tx_valid_o drops asynchronously.
- Echo latency: rx_valid_i at edge N → echo_pend at N+1 → tx_valid_o at N+2 (output idle, no contention).
- Message latency: msg_start_i at edge N → M_READ N+1, M_LATCH N+2, msg_pend N+3, tx_valid_o N+4.
- Next message byte: grant edge G → M_READ G+1 → msg_pend G+3.
- Simultaneous msg_start_i and rx_valid_i: both accepted independently.
- tx_ready_i high with tx_valid_o=0: no effect.

## Test plan
- ROM[0x10..0x12]="ABC",ROM[0x13]=0x00; start base 0x10, tx_ready_i=1 → tx sees 0x41,0x42,0x43; msg_done_o one pulse; first tx_valid_o 4 cycles after start.
- Base 0x7E, ROM[0x7E]=0x31, ROM[0x7F]=0x32, no terminator → 0x31,0x32 sent, done after 0x7F, rom_addr_o never 0x00 after start; base 0x80 → msg_done_o 2 cycles after start, no tx_valid_o.
- Message "ABCD" playing, rx bytes 0x61,0x62 arriving one per byte time, echo_en_i=1 → interleaved 0x41,0x61,0x42,0x62,0x43,0x44.
- tx_ready_i=0, rx 0x55 then 0x66 then 0x77 → 0x55 on tx_data_o held, 0x66 in echo_buf, 0x77 dropped with echo_ovf_o pulse; release ready → 0x55,0x66.
- rx 0x11 with echo_en_i=0 → no tx_valid_o, no echo_ovf_o; msg_start_i while busy → ignored, single msg_done_o.
- Assert rst_n low while tx_valid_o=1 mid-message → all outputs at reset values immediately; after release, new start plays from new base cleanly.
